mem_port_arbiter: RTL

- Shares the Chip's single-port synchronous data/instruction RAM between two requesters: the instruction-fetch unit (IF, read-only) and the load/store unit (LS, read/write).
- Sits between the CPU core datapath and the memory macro.
- Serialises accesses with one transaction outstanding and a fixed read latency.
- Gives LS priority, with a starvation guard for IF.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter_prio.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LS memory port arbiter.
// FSM states, owner encoding and counter widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam int BE_W     = 4;
  localparam int CNT_W    = 3;
  localparam int STARVE_W = 4;

  localparam logic [BE_W-1:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bundle of the memory port arbiter.
// slave: arbiter view; master: core/memory view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [BE_W-1:0]   ls_be;
  logic [DATA_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  busy
  );

endinterface

// File: rtl/mem_port_arbiter_prio.sv
// LS-priority winner select with an IF starvation guard.
// starve_cnt counts LS wins while IF waits; saturates at the limit.
module arb_prio_starve
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic ls_req,
  input  logic grant_en,
  output logic sel_ls
);

  localparam logic [STARVE_W-1:0] LIMIT =
    STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;
  logic                take;

  assign starved = (starve_cnt >= LIMIT);
  assign sel_ls  = ls_req && !(if_req && starved);
  assign take    = grant_en && (if_req || ls_req);

  // Count LS wins over a waiting IF; clear on IF wins or lone LS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (take) begin
      if (sel_ls && if_req) begin
        if (!starved)
          starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store.
// One outstanding access, fixed read latency, LS priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT_M1 =
    CNT_W'(MEM_LATENCY - 1);

  state_t          state;
  owner_t          owner;
  logic            owner_we;
  logic [CNT_W-1:0] cnt;
  logic            if_rv;
  logic            ls_rv;
  logic            busy_q;

  logic grant_en;
  logic sel_ls;
  logic take;

  // Grants only from IDLE and never while reset is asserted.
  assign grant_en = rst_n && (state == IDLE);
  assign take     = grant_en && (bus.if_req || bus.ls_req);

  arb_prio_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_req  (bus.if_req),
    .ls_req  (bus.ls_req),
    .grant_en(grant_en),
    .sel_ls  (sel_ls)
  );

  // Same-cycle grant: route the winner onto the memory port.
  always_comb begin
    bus.if_gnt    = 1'b0;
    bus.ls_gnt    = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (take) begin
      bus.mem_en = 1'b1;
      if (sel_ls) begin
        bus.ls_gnt    = 1'b1;
        bus.mem_we    = bus.ls_we;
        bus.mem_be    = bus.ls_be;
        bus.mem_addr  = bus.ls_addr[DATA_W-1:2];
        bus.mem_wdata = bus.ls_wdata;
      end else begin
        bus.if_gnt   = 1'b1;
        bus.mem_be   = BE_FULL;
        bus.mem_addr = bus.if_addr[DATA_W-1:2];
      end
    end
  end

  // Transaction FSM: rvalid lands exactly MEM_LATENCY after grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      owner_we <= 1'b0;
      cnt      <= '0;
      if_rv    <= 1'b0;
      ls_rv    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if_rv <= 1'b0;
      ls_rv <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            owner    <= sel_ls ? OWN_LS : OWN_IF;
            owner_we <= sel_ls && bus.ls_we;
            cnt      <= LAT_M1;
            busy_q   <= 1'b1;
            if (LAT_M1 == '0) begin
              state <= RESP;
              if_rv <= !sel_ls;
              ls_rv <= sel_ls;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= RESP;
            if_rv <= (owner == OWN_IF);
            ls_rv <= (owner == OWN_LS);
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_rvalid = if_rv;
  assign bus.ls_rvalid = ls_rv;
  assign bus.busy      = busy_q;
  assign bus.if_rdata  = if_rv ? bus.mem_rdata : '0;
  assign bus.ls_rdata  = (ls_rv && !owner_we) ?
                         bus.mem_rdata : '0;

  logic unused_addr_lsb;
  assign unused_addr_lsb =
    ^{bus.if_addr[1:0], bus.ls_addr[1:0]};

`ifndef SYNTHESIS
  logic                       if_pend;
  logic                       ls_pend;
  logic [DATA_W*2+BE_W:0]     ls_q;

  // Remember who was waiting and the LS fields they presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_pend <= 1'b0;
      ls_pend <= 1'b0;
      ls_q    <= '0;
    end else begin
      if_pend <= bus.if_req && !bus.if_gnt;
      ls_pend <= bus.ls_req && !bus.ls_gnt;
      ls_q    <= {bus.ls_we, bus.ls_be,
                  bus.ls_addr, bus.ls_wdata};
    end
  end

  // Requests must hold, with stable LS fields, until granted.
  always @(posedge clk) begin
    if (rst_n && if_pend)
      a_if_hold: assert (bus.if_req);
    if (rst_n && ls_pend)
      a_ls_hold: assert (bus.ls_req &&
        ({bus.ls_we, bus.ls_be, bus.ls_addr,
          bus.ls_wdata} == ls_q));
  end
`endif

endmodule
